// File: rtl/sw_pkg.sv
// Shared constants, counter-width helper and request FSM state type for the
// switch request conditioner.
package sw_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

    // Width able to hold DEBOUNCE_CYCLES-1, never below one bit.
    function automatic int unsigned sw_cnt_w(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    typedef enum logic {
        REQ_IDLE,
        REQ_PEND
    } req_state_e;

endpackage

// File: rtl/sw_debounce_ch.sv
// Single switch channel: two-flop synchroniser followed by a debounce counter.
// Emits the committed level and a one-cycle pulse on a committed 0->1 edge.
module sw_debounce_ch
    import sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sw_i,
    output logic level_o,
    output logic press_pulse_o
);

    localparam int unsigned CNT_W = sw_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o       = level_q;
    // Combinational so the request latch can rise on the same edge as the level.
    assign press_pulse_o = level_d & ~level_q;

endmodule

// File: rtl/sw_request_conditioner.sv
// Switch front end: per-channel debounce, latched requests with valid/ack and
// sticky overflow. SW_PRESS_COUNT_EN adds saturating per-channel press counters.
module sw_request_conditioner
    import sw_pkg::*;
#(
    parameter int unsigned NUM_SW          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SW-1:0]     sw_in,
    input  logic [NUM_SW-1:0]     req_ack,
    input  logic                  ovf_clr,
    output logic [NUM_SW-1:0]     sw_level,
    output logic [NUM_SW-1:0]     req_valid,
    output logic [NUM_SW-1:0]     req_ovf,
    output logic [8*NUM_SW-1:0]   press_cnt
);

    logic [NUM_SW-1:0] press;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        req_state_e state_q;
        logic       ovf_q;

        sw_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i        (clk),
            .reset_i      (reset),
            .sw_i         (sw_in[i]),
            .level_o      (sw_level[i]),
            .press_pulse_o(press[i])
        );

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= REQ_IDLE;
                ovf_q   <= 1'b0;
            end else begin
                case (state_q)
                    REQ_IDLE: if (press[i]) state_q <= REQ_PEND;
                    // A press landing with the ack re-arms the request immediately.
                    REQ_PEND: if (req_ack[i] && !press[i]) state_q <= REQ_IDLE;
                    default:  state_q <= REQ_IDLE;
                endcase
                if (state_q == REQ_PEND && press[i] && !req_ack[i]) begin
                    ovf_q <= 1'b1;
                end else if (ovf_clr) begin
                    ovf_q <= 1'b0;
                end
            end
        end

        assign req_valid[i] = (state_q == REQ_PEND);
        assign req_ovf[i]   = ovf_q;

`ifdef SW_PRESS_COUNT_EN
        logic [7:0] pcnt_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                pcnt_q <= 8'd0;
            end else if (press[i] && pcnt_q != 8'hFF) begin
                pcnt_q <= pcnt_q + 8'd1;
            end
        end

        assign press_cnt[8*i +: 8] = pcnt_q;
`endif
    end

`ifndef SW_PRESS_COUNT_EN
    assign press_cnt = '0;
`endif

endmodule

// File: tb/tb_sw_request_conditioner.sv
// Directed bench for sw_request_conditioner with DEBOUNCE_CYCLES=4.
module tb_sw_request_conditioner;

    localparam int unsigned NSW = 3;

    logic             clk;
    logic             reset;
    logic [NSW-1:0]   sw_in;
    logic [NSW-1:0]   req_ack;
    logic             ovf_clr;
    logic [NSW-1:0]   sw_level;
    logic [NSW-1:0]   req_valid;
    logic [NSW-1:0]   req_ovf;
    logic [8*NSW-1:0] press_cnt;

    int tests = 0;
    int fails = 0;

    sw_request_conditioner #(
        .NUM_SW         (NSW),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_in    (sw_in),
        .req_ack  (req_ack),
        .ovf_clr  (ovf_clr),
        .sw_level (sw_level),
        .req_valid(req_valid),
        .req_ovf  (req_ovf),
        .press_cnt(press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef SW_PRESS_COUNT_EN
    localparam int CntEn = 1;
`else
    localparam int CntEn = 0;
`endif

    initial begin
        reset   = 1'b1;
        sw_in   = '0;
        req_ack = '0;
        ovf_clr = 1'b0;
        step(2);
        check("rst_level", 32'(sw_level), 32'h0);
        check("rst_valid", 32'(req_valid), 32'h0);
        check("rst_ovf", 32'(req_ovf), 32'h0);
        check("rst_cnt", 32'(press_cnt), 32'h0);
        reset = 1'b0;

        // Clean press on channel 0: sampled at the next edge, level 5 edges after that.
        sw_in[0] = 1'b1;
        step(5);
        check("press_early_level", 32'(sw_level), 32'h0);
        check("press_early_valid", 32'(req_valid), 32'h0);
        step(1);
        check("press_level", 32'(sw_level), 32'h1);
        check("press_valid", 32'(req_valid), 32'h1);

        // Handshake.
        req_ack[0] = 1'b1;
        step(1);
        check("ack_clears", 32'(req_valid), 32'h0);
        step(1);
        check("ack_idle_ignored", 32'(req_valid), 32'h0);
        req_ack[0] = 1'b0;
        sw_in[0] = 1'b0;
        step(6);
        check("release_level", 32'(sw_level), 32'h0);
        check("release_no_event", 32'(req_valid), 32'h0);
        sw_in[0] = 1'b1;
        step(6);
        check("repress_valid", 32'(req_valid), 32'h1);
        check("repress_ovf", 32'(req_ovf), 32'h0);

        // Second press while pending -> sticky overflow.
        sw_in[0] = 1'b0;
        step(6);
        sw_in[0] = 1'b1;
        step(5);
        check("ovf_before", 32'(req_ovf), 32'h0);
        step(1);
        check("ovf_set", 32'(req_ovf), 32'h1);
        check("ovf_valid", 32'(req_valid), 32'h1);
        step(3);
        check("ovf_sticky", 32'(req_ovf), 32'h1);
        ovf_clr = 1'b1;
        step(1);
        check("ovf_clr", 32'(req_ovf), 32'h0);
        ovf_clr = 1'b0;

        // Ack on the exact edge of a new press keeps the request pending.
        sw_in[0] = 1'b0;
        step(6);
        sw_in[0] = 1'b1;
        step(5);
        req_ack[0] = 1'b1;
        step(1);
        req_ack[0] = 1'b0;
        check("ackpress_valid", 32'(req_valid), 32'h1);
        check("ackpress_ovf", 32'(req_ovf), 32'h0);

        // Overflow set coinciding with ovf_clr: set wins.
        sw_in[0] = 1'b0;
        step(6);
        sw_in[0] = 1'b1;
        step(5);
        ovf_clr = 1'b1;
        step(1);
        check("ovf_set_wins", 32'(req_ovf), 32'h1);
        step(1);
        check("ovf_clr_after", 32'(req_ovf), 32'h0);
        ovf_clr = 1'b0;
        req_ack[0] = 1'b1;
        step(1);
        req_ack[0] = 1'b0;
        sw_in[0] = 1'b0;
        step(6);
        check("ch0_drained", 32'(req_valid), 32'h0);

        // Bounce on channel 1: 2-cycle toggles never commit.
        for (int k = 0; k < 6; k++) begin
            sw_in[1] = ~sw_in[1];
            step(2);
            check("bounce_level", 32'(sw_level[1]), 32'h0);
            check("bounce_valid", 32'(req_valid[1]), 32'h0);
        end
        sw_in[1] = 1'b0;
        step(8);
        check("bounce_settle_level", 32'(sw_level[1]), 32'h0);
        check("bounce_cnt", 32'(press_cnt[15:8]), 32'h0);

        // Glitch of DEBOUNCE_CYCLES-1 rejected; exactly DEBOUNCE_CYCLES accepted.
        sw_in[1] = 1'b1;
        step(3);
        sw_in[1] = 1'b0;
        step(8);
        check("glitch3_level", 32'(sw_level[1]), 32'h0);
        check("glitch3_valid", 32'(req_valid[1]), 32'h0);
        sw_in[2] = 1'b1;
        step(4);
        sw_in[2] = 1'b0;
        step(2);
        check("pulse4_valid", 32'(req_valid), 32'h4);
        step(8);
        check("pulse4_release", 32'(sw_level), 32'h0);

        // Reset two cycles into a debounce window discards everything.
        sw_in[2] = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        check("midrst_level", 32'(sw_level), 32'h0);
        check("midrst_valid", 32'(req_valid), 32'h0);
        check("midrst_ovf", 32'(req_ovf), 32'h0);
        check("midrst_cnt", 32'(press_cnt), 32'h0);
        reset = 1'b0;
        step(5);
        check("postrst_early", 32'(sw_level), 32'h0);
        step(1);
        check("postrst_level", 32'(sw_level), 32'h4);
        check("postrst_valid", 32'(req_valid), 32'h4);
        check("postrst_cnt2", 32'(press_cnt[23:16]), 32'(CntEn));

        // Press counter: 10 presses, then saturate past 255.
        for (int k = 0; k < 10; k++) begin
            sw_in[0] = 1'b1;
            step(6);
            sw_in[0] = 1'b0;
            step(6);
        end
        check("cnt_10", 32'(press_cnt[7:0]), 32'(CntEn * 10));
        for (int k = 0; k < 290; k++) begin
            sw_in[0] = 1'b1;
            step(6);
            sw_in[0] = 1'b0;
            step(6);
        end
        check("cnt_sat", 32'(press_cnt[7:0]), 32'(CntEn * 255));
        check("cnt_ch1", 32'(press_cnt[15:8]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
